evm_id_database: RTL and testbench

Identity and authorisation database for the electronic voting machine (EVM). It checks the presiding-officer ID and the reset (admin) ID. It looks up voter IDs against a 16-entry registered-voter table and keeps a per-voter "has voted" flag to block double voting. On a successful lookup it issues a one-cycle write strobe plus voter ID and address, which the downstream vote-recording logic consumes.

---
 rtl/evm_id_database.sv | 112 +++++++++++
 tb/tb_evm_id_database.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/evm_id_database.sv
// evm_id_database
// Identity and authorisation database for the voting machine. It validates the
// presiding-officer ID and the admin reset ID, and checks presented voter IDs
// against a registered-voter table. A has-voted flag per voter blocks double
// voting. Every output is registered, so each one reflects the inputs sampled
// on the previous rising edge.

module evm_id_database #(
    parameter logic [4:0] OFFICER_ID = 5'b11111,
    parameter logic [4:0] RESET_ID   = 5'b11110,
    parameter int         NUM_VOTERS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       control,
    input  logic       read_enable,
    input  logic [4:0] officer_id,
    input  logic [4:0] voter_id,
    input  logic [4:0] reset_id,
    output logic       officer_id_status,
    output logic       reset_id_status,
    output logic       voter_id_status,
    output logic [4:0] valid_voter,
    output logic [3:0] valid_voter_address,
    output logic       write
);

    // Widened by one bit so that a value of 16 still fits.
    localparam logic [5:0] VOTER_LIMIT = 6'(NUM_VOTERS);

    logic [15:0] has_voted_r;
    logic [15:0] has_voted_next_s;
    logic        off_ok_s;
    logic        clear_s;
    logic        in_range_s;
    logic        accept_s;
    logic [3:0]  voter_addr_s;

    // Decode the authorisation, the clear request and the voter acceptance
    // for this cycle.
    always_comb begin
        off_ok_s         = 1'b0;
        clear_s          = 1'b0;
        in_range_s       = 1'b0;
        accept_s         = 1'b0;
        voter_addr_s     = voter_id[3:0];
        has_voted_next_s = has_voted_r;

        off_ok_s   = (officer_id == OFFICER_ID);
        in_range_s = ({1'b0, voter_id} < VOTER_LIMIT);

        if (control == 1'b1) begin
            if ((mode == 1'b0) && off_ok_s && (reset_id == RESET_ID)) begin
                clear_s = 1'b1;
            end else begin
                clear_s = 1'b0;
            end

            // If a compare is unknown, the condition counts as false, so no
            // flag is set.
            if ((mode == 1'b1) && (read_enable == 1'b1) && off_ok_s && in_range_s &&
                (has_voted_r[voter_addr_s] == 1'b0)) begin
                accept_s = 1'b1;
            end else begin
                accept_s = 1'b0;
            end
        end else begin
            clear_s  = 1'b0;
            accept_s = 1'b0;
        end

        // The two modes are exclusive, so a clear and a vote never occur in
        // the same cycle.
        if (clear_s) begin
            has_voted_next_s = 16'h0000;
        end else if (accept_s) begin
            has_voted_next_s = has_voted_r | (16'h0001 << voter_addr_s);
        end else begin
            has_voted_next_s = has_voted_r;
        end
    end

    // Register the flag table and all outputs. When control is 0, the status
    // outputs and the write strobe are forced to 0, and the flags and the last
    // accepted voter are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            has_voted_r         <= 16'h0000;
            officer_id_status   <= 1'b0;
            reset_id_status     <= 1'b0;
            voter_id_status     <= 1'b0;
            write               <= 1'b0;
            valid_voter         <= 5'b00000;
            valid_voter_address <= 4'b0000;
        end else begin
            has_voted_r       <= has_voted_next_s;
            officer_id_status <= control & off_ok_s;
            reset_id_status   <= clear_s;
            voter_id_status   <= accept_s;
            write             <= accept_s;
            if (accept_s) begin
                valid_voter         <= voter_id;
                valid_voter_address <= voter_addr_s;
            end else begin
                valid_voter         <= valid_voter;
                valid_voter_address <= valid_voter_address;
            end
        end
    end

endmodule

// File: tb/tb_evm_id_database.sv
// tb_evm_id_database
// Table-driven directed vectors, an asynchronous-reset sequence, and randomised
// traffic. The random traffic is checked against a reference model that keeps
// the set of voters who have already voted as a queue of IDs.

module tb_evm_id_database;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       control;
    logic       read_enable;
    logic [4:0] officer_id;
    logic [4:0] voter_id;
    logic [4:0] reset_id;
    logic       officer_id_status;
    logic       reset_id_status;
    logic       voter_id_status;
    logic [4:0] valid_voter;
    logic [3:0] valid_voter_address;
    logic       write;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int         voted_q[$];
    logic       m_off, m_rs, m_vs, m_wr;
    logic [4:0] m_vv;
    logic [3:0] m_va;

    typedef struct {
        bit         mode;
        bit         control;
        bit         re;
        logic [4:0] off;
        logic [4:0] vid;
        logic [4:0] rid;
        bit         e_off;
        bit         e_rs;
        bit         e_vs;
        bit         e_wr;
        logic [4:0] e_vv;
        logic [3:0] e_va;
    } vec_t;

    vec_t vecs[$];

    evm_id_database dut (
        .clk                 (clk),
        .rst                 (rst),
        .mode                (mode),
        .control             (control),
        .read_enable         (read_enable),
        .officer_id          (officer_id),
        .voter_id            (voter_id),
        .reset_id            (reset_id),
        .officer_id_status   (officer_id_status),
        .reset_id_status     (reset_id_status),
        .voter_id_status     (voter_id_status),
        .valid_voter         (valid_voter),
        .valid_voter_address (valid_voter_address),
        .write               (write)
    );

    // 10 ns clock period.
    always #5 clk = ~clk;

    function automatic logic [12:0] dut_vec();
        return {officer_id_status, reset_id_status, voter_id_status, write,
                valid_voter, valid_voter_address};
    endfunction

    function automatic logic [12:0] model_vec();
        return {m_off, m_rs, m_vs, m_wr, m_vv, m_va};
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got off/rs/vs/wr/vv/va=%b exp=%b", name, got, exp);
        end
    endtask

    function automatic bit has_voted(input int id);
        foreach (voted_q[i]) begin
            if (voted_q[i] == id) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Update the model from the current inputs to match the next edge.
    task automatic model_step();
        if (!control) begin
            m_off = 1'b0; m_rs = 1'b0; m_vs = 1'b0; m_wr = 1'b0;
        end else begin
            m_off = (officer_id == 5'd31);
            m_rs = 1'b0; m_vs = 1'b0; m_wr = 1'b0;
            if (!mode && m_off && reset_id == 5'd30) begin
                voted_q.delete();
                m_rs = 1'b1;
            end else if (mode && read_enable && m_off && int'(voter_id) < 16 &&
                         !has_voted(int'(voter_id))) begin
                voted_q.push_back(int'(voter_id));
                m_vs = 1'b1;
                m_wr = 1'b1;
                m_vv = voter_id;
                m_va = voter_id[3:0];
            end
        end
    endtask

    task automatic model_reset();
        voted_q.delete();
        m_off = 1'b0; m_rs = 1'b0; m_vs = 1'b0; m_wr = 1'b0;
        m_vv = 5'd0; m_va = 4'd0;
    endtask

    task automatic drive(input bit md, input bit ct, input bit re,
                         input logic [4:0] off, input logic [4:0] vid, input logic [4:0] rid);
        mode = md; control = ct; read_enable = re;
        officer_id = off; voter_id = vid; reset_id = rid;
    endtask

    // Compact vector builder: inputs, then the expected outputs.
    task automatic addv(input bit md, input bit ct, input bit re,
                        input logic [4:0] off, input logic [4:0] vid, input logic [4:0] rid,
                        input bit eo, input bit er, input bit ev, input bit ew,
                        input logic [4:0] evv, input logic [3:0] eva);
        vec_t v;
        v.mode = md; v.control = ct; v.re = re; v.off = off; v.vid = vid; v.rid = rid;
        v.e_off = eo; v.e_rs = er; v.e_vs = ev; v.e_wr = ew; v.e_vv = evv; v.e_va = eva;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 13'd0);
        rst = 1'b0;

        // Basic vote sequence.
        addv(1,1,1,5'd31,5'd0 ,5'd0, 1,0,1,1,5'd0,4'd0);
        addv(1,1,1,5'd31,5'd2 ,5'd0, 1,0,1,1,5'd2,4'd2);
        addv(1,1,1,5'd31,5'd0 ,5'd0, 1,0,0,0,5'd2,4'd2);
        addv(1,1,1,5'd31,5'd2 ,5'd0, 1,0,0,0,5'd2,4'd2);
        addv(1,1,1,5'd31,5'd24,5'd0, 1,0,0,0,5'd2,4'd2);
        // A held voter ID is accepted only once.
        addv(1,1,1,5'd31,5'd5 ,5'd0, 1,0,1,1,5'd5,4'd5);
        addv(1,1,1,5'd31,5'd5 ,5'd0, 1,0,0,0,5'd5,4'd5);
        addv(1,1,1,5'd31,5'd5 ,5'd0, 1,0,0,0,5'd5,4'd5);
        // Wrong officer ID, then the correct one.
        addv(1,1,1,5'd30,5'd1 ,5'd0, 0,0,0,0,5'd5,4'd5);
        addv(1,1,1,5'd31,5'd1 ,5'd0, 1,0,1,1,5'd1,4'd1);
        // Admin clear: a wrong reset ID first, then the correct one.
        addv(1,1,1,5'd31,5'd3 ,5'd0 , 1,0,1,1,5'd3,4'd3);
        addv(0,1,1,5'd31,5'd3 ,5'd21, 1,0,0,0,5'd3,4'd3);
        addv(1,1,1,5'd31,5'd3 ,5'd0 , 1,0,0,0,5'd3,4'd3);
        addv(0,1,1,5'd31,5'd3 ,5'd30, 1,1,0,0,5'd3,4'd3);
        addv(1,1,1,5'd31,5'd3 ,5'd0 , 1,0,1,1,5'd3,4'd3);
        addv(1,1,1,5'd31,5'd0 ,5'd0 , 1,0,1,1,5'd0,4'd0);
        // control = 0 freezes the state.
        addv(1,0,1,5'd31,5'd7 ,5'd0 , 0,0,0,0,5'd0,4'd0);
        addv(1,1,1,5'd31,5'd7 ,5'd0 , 1,0,1,1,5'd7,4'd7);
        // A clear with a bad officer ID has no effect.
        addv(0,1,0,5'd0 ,5'd7 ,5'd30, 0,0,0,0,5'd7,4'd7);
        addv(1,1,1,5'd31,5'd7 ,5'd0 , 1,0,0,0,5'd7,4'd7);
        // read_enable gating.
        addv(1,1,0,5'd31,5'd8 ,5'd0 , 1,0,0,0,5'd7,4'd7);
        addv(1,1,1,5'd31,5'd8 ,5'd0 , 1,0,1,1,5'd8,4'd8);
        // Range boundary: 15 is the last valid ID, 16 is out of range.
        addv(1,1,1,5'd31,5'd15,5'd0 , 1,0,1,1,5'd15,4'd15);
        addv(1,1,1,5'd31,5'd16,5'd0 , 1,0,0,0,5'd15,4'd15);

        foreach (vecs[i]) begin
            drive(vecs[i].mode, vecs[i].control, vecs[i].re,
                  vecs[i].off, vecs[i].vid, vecs[i].rid);
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), dut_vec(),
                  {vecs[i].e_off, vecs[i].e_rs, vecs[i].e_vs, vecs[i].e_wr,
                   vecs[i].e_vv, vecs[i].e_va});
        end

        // Assert rst between edges: the outputs must clear at once.
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset", dut_vec(), 13'd0);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 5'd31, 5'd0, 5'd0);
        model_step();
        @(posedge clk);
        #1;
        check("revote_after_reset", dut_vec(), {1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 4'd0});

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) != 0) ? 5'd31 : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 5) != 0) ? 5'($urandom_range(0, 15))
                                              : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 7) == 0) ? 5'd30 : 5'($urandom_range(0, 31)));
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("rand%0d", i), dut_vec(), model_vec());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
